// File: rtl/wb_stage_mlane_pkg.sv
// Shared types and lane-layout helpers for the multi-lane write-back stage.
// A lane is packed as {dest, we, result, pc} with pc in the LSBs.
package wb_stage_mlane_pkg;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_e;

  function automatic int lane_w(input int addr_w, input int data_w, input int pc_w);
    return addr_w + 1 + data_w + pc_w;
  endfunction

  function automatic int data_off(input int pc_w);
    return pc_w;
  endfunction

  function automatic int we_off(input int data_w, input int pc_w);
    return pc_w + data_w;
  endfunction

  function automatic int dest_off(input int data_w, input int pc_w);
    return pc_w + data_w + 1;
  endfunction

endpackage

// File: rtl/wb_stage_mlane_lane_pick.sv
// Combinational lane picker: lowest set bit of mask at or above (inclusive) or strictly
// above the cursor. 'found' low means no such lane exists.
module wb_lane_pick #(
  parameter int LANES = 2,
  parameter int IDX_W = 1
) (
  input  logic [LANES-1:0] mask,
  input  logic [IDX_W-1:0] cur,
  input  logic             inclusive,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    idx   = '0;
    found = 1'b0;
    // Descending scan so the lowest qualifying lane is the last one assigned.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur)) || (inclusive && (i == int'(cur))))) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_stage_mlane.sv
// Multi-lane write-back stage: registers a MEM->WB bundle, masks same-destination
// collisions and drains it into RF_PORTS regfile write ports, serially when RF_PORTS==1.
module wb_stage_mlane
  import wb_stage_mlane_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int RF_PORTS = 1,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PC_W     = 32,
  localparam int LANE_W  = lane_w(ADDR_W, DATA_W, PC_W)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       mem_valid_i,
  input  logic [LANES*LANE_W-1:0]    mem2wb_bus_i,
  output logic                       wb_allowin_o,
  input  logic                       flush_i,
  output logic [RF_PORTS-1:0]        rf_we_o,
  output logic [RF_PORTS*ADDR_W-1:0] rf_wdest_o,
  output logic [RF_PORTS*DATA_W-1:0] rf_wdata_o,
  output logic [LANES*ADDR_W-1:0]    ctl_wb_dest_o,
  output logic                       ctl_wb_over_o,
  output logic [63:0]                retire_cnt_o
);

  localparam int IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam bit SERIAL   = (RF_PORTS != LANES);
  localparam int DATA_OFF = data_off(PC_W);
  localparam int WE_OFF   = we_off(DATA_W, PC_W);
  localparam int DEST_OFF = dest_off(DATA_W, PC_W);

  if (!((RF_PORTS == 1) || (RF_PORTS == LANES))) begin : g_bad_ports
    $error("wb_stage_mlane: RF_PORTS must be 1 or LANES");
  end
  if ((LANES < 1) || (LANES > 4)) begin : g_bad_lanes
    $error("wb_stage_mlane: LANES must be in 1..4");
  end

  // Incoming lane fields
  logic [ADDR_W-1:0] in_dest [LANES];
  logic [DATA_W-1:0] in_data [LANES];
  logic [LANES-1:0]  in_we;
  logic [LANES-1:0]  in_act;
  logic [LANES-1:0]  in_keep;
  logic              unused_pc;

  always_comb begin
    unused_pc = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      in_dest[i] = mem2wb_bus_i[i*LANE_W + DEST_OFF +: ADDR_W];
      in_data[i] = mem2wb_bus_i[i*LANE_W + DATA_OFF +: DATA_W];
      in_we[i]   = mem2wb_bus_i[i*LANE_W + WE_OFF];
      in_act[i]  = in_we[i] && (in_dest[i] != '0);
      unused_pc  = unused_pc ^ (^mem2wb_bus_i[i*LANE_W +: PC_W]);
    end
  end

  // Collision masking: a lane survives only if no higher active lane targets the same dest.
  always_comb begin
    in_keep = in_act;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (in_act[j] && (in_dest[j] == in_dest[i])) in_keep[i] = 1'b0;
      end
    end
  end

  // Pipeline register and drain state
  wb_state_e         state_q;
  logic [LANES-1:0]  pend_q;
  logic [IDX_W-1:0]  cur_q;
  logic [63:0]       cnt_q;
  logic [ADDR_W-1:0] dest_q [LANES];
  logic [DATA_W-1:0] data_q [LANES];

  logic [IDX_W-1:0]  first_idx;
  logic              first_found;
  logic [IDX_W-1:0]  nxt_idx;
  logic              nxt_found;
  logic              is_write;
  logic              drain_last;
  logic              capture;
  logic              over;

  wb_lane_pick #(.LANES(LANES), .IDX_W(IDX_W)) u_pick_first (
    .mask      (in_keep),
    .cur       ('0),
    .inclusive (1'b1),
    .idx       (first_idx),
    .found     (first_found)
  );

  wb_lane_pick #(.LANES(LANES), .IDX_W(IDX_W)) u_pick_next (
    .mask      (pend_q),
    .cur       (cur_q),
    .inclusive (1'b0),
    .idx       (nxt_idx),
    .found     (nxt_found)
  );

  // An empty bundle leaves cursor 0 with nothing pending: one WRITE cycle with no enable.
  logic unused_first_found;
  assign unused_first_found = first_found;

  assign is_write      = (state_q == WB_WRITE);
  assign drain_last    = SERIAL ? !nxt_found : 1'b1;
  assign wb_allowin_o  = !is_write || drain_last;
  assign capture       = mem_valid_i && wb_allowin_o && !flush_i;
  assign over          = is_write && drain_last && !flush_i;
  assign ctl_wb_over_o = over;
  assign retire_cnt_o  = cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= WB_EMPTY;
      pend_q  <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (over) cnt_q <= cnt_q + 64'(LANES);
      if (flush_i) begin
        state_q <= WB_EMPTY;
        pend_q  <= '0;
      end else if (capture) begin
        state_q <= WB_WRITE;
        pend_q  <= in_keep;
        cur_q   <= first_idx;
      end else if (is_write && drain_last) begin
        state_q <= WB_EMPTY;
        pend_q  <= '0;
      end else if (is_write) begin
        pend_q[cur_q] <= 1'b0;
        cur_q         <= nxt_idx;
      end
    end
  end

  // NOTE: payload registers carry no reset; every consumer is qualified by pend_q, which is reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < LANES; i++) begin
        dest_q[i] <= in_dest[i];
        data_q[i] <= in_data[i];
      end
    end
  end

  always_comb begin
    ctl_wb_dest_o = '0;
    for (int i = 0; i < LANES; i++) begin
      if (pend_q[i]) ctl_wb_dest_o[i*ADDR_W +: ADDR_W] = dest_q[i];
    end
  end

  if (SERIAL) begin : g_serial
    assign rf_we_o[0]              = is_write && pend_q[cur_q] && !flush_i;
    assign rf_wdest_o[ADDR_W-1:0]  = dest_q[cur_q];
    assign rf_wdata_o[DATA_W-1:0]  = data_q[cur_q];
  end else begin : g_parallel
    for (genvar p = 0; p < RF_PORTS; p++) begin : g_port
      assign rf_we_o[p]                     = is_write && pend_q[p] && !flush_i;
      assign rf_wdest_o[p*ADDR_W +: ADDR_W] = dest_q[p];
      assign rf_wdata_o[p*DATA_W +: DATA_W] = data_q[p];
    end
  end

endmodule

// File: tb/tb_wb_stage_mlane.sv
// Directed bench for wb_stage_mlane: a serial (LANES=2, RF_PORTS=1) and a parallel
// (LANES=2, RF_PORTS=2) instance driven with hand-computed vectors.
module tb_wb_stage_mlane;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int LANE_W = ADDR_W + 1 + DATA_W + PC_W;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Serial instance
  logic                s_valid, s_flush, s_allowin, s_we, s_over;
  logic [2*LANE_W-1:0] s_bus;
  logic [ADDR_W-1:0]   s_wdest;
  logic [DATA_W-1:0]   s_wdata;
  logic [2*ADDR_W-1:0] s_cdest;
  logic [63:0]         s_cnt;

  // Parallel instance
  logic                p_valid, p_flush, p_allowin, p_over;
  logic [1:0]          p_we;
  logic [2*LANE_W-1:0] p_bus;
  logic [2*ADDR_W-1:0] p_wdest;
  logic [2*DATA_W-1:0] p_wdata;
  logic [2*ADDR_W-1:0] p_cdest;
  logic [63:0]         p_cnt;

  wb_stage_mlane #(.LANES(2), .RF_PORTS(1), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) u_ser (
    .clk(clk), .resetn(resetn), .mem_valid_i(s_valid), .mem2wb_bus_i(s_bus),
    .wb_allowin_o(s_allowin), .flush_i(s_flush), .rf_we_o(s_we), .rf_wdest_o(s_wdest),
    .rf_wdata_o(s_wdata), .ctl_wb_dest_o(s_cdest), .ctl_wb_over_o(s_over), .retire_cnt_o(s_cnt)
  );

  wb_stage_mlane #(.LANES(2), .RF_PORTS(2), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) u_par (
    .clk(clk), .resetn(resetn), .mem_valid_i(p_valid), .mem2wb_bus_i(p_bus),
    .wb_allowin_o(p_allowin), .flush_i(p_flush), .rf_we_o(p_we), .rf_wdest_o(p_wdest),
    .rf_wdata_o(p_wdata), .ctl_wb_dest_o(p_cdest), .ctl_wb_over_o(p_over), .retire_cnt_o(p_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LANE_W-1:0] lane(input logic [ADDR_W-1:0] dest, input logic we,
                                             input logic [DATA_W-1:0] data, input logic [PC_W-1:0] pc);
    return {dest, we, data, pc};
  endfunction

  // Advance one clock; outputs are sampled 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    resetn  = 1'b0;
    s_valid = 1'b0; s_flush = 1'b0; s_bus = '0;
    p_valid = 1'b0; p_flush = 1'b0; p_bus = '0;
    #1;
    check("rst_allowin", 64'(s_allowin), 64'd1);
    check("rst_we",      64'(s_we),      64'd0);
    check("rst_cdest",   64'(s_cdest),   64'd0);
    check("rst_over",    64'(s_over),    64'd0);
    check("rst_cnt",     s_cnt,          64'd0);
    check("rst_p_we",    64'(p_we),      64'd0);
    repeat (2) step();
    resetn = 1'b1;
    step();

    // Serial drain of two lanes: r3<=0x11 then r7<=0x22
    s_bus   = {lane(5'd7, 1'b1, 32'h22, 32'h104), lane(5'd3, 1'b1, 32'h11, 32'h100)};
    s_valid = 1'b1;
    #1;
    check("ser_allowin_empty", 64'(s_allowin), 64'd1);
    step();
    s_valid = 1'b0;
    check("ser_c1_we",      64'(s_we),      64'd1);
    check("ser_c1_dest",    64'(s_wdest),   64'd3);
    check("ser_c1_data",    64'(s_wdata),   64'h11);
    check("ser_c1_over",    64'(s_over),    64'd0);
    check("ser_c1_allowin", 64'(s_allowin), 64'd0);
    check("ser_c1_cdest",   64'(s_cdest),   64'h0E3);
    step();
    check("ser_c2_we",      64'(s_we),      64'd1);
    check("ser_c2_dest",    64'(s_wdest),   64'd7);
    check("ser_c2_data",    64'(s_wdata),   64'h22);
    check("ser_c2_over",    64'(s_over),    64'd1);
    check("ser_c2_allowin", 64'(s_allowin), 64'd1);
    check("ser_c2_cdest",   64'(s_cdest),   64'h0E0);
    step();
    check("ser_done_we",    64'(s_we),      64'd0);
    check("ser_done_cnt",   s_cnt,          64'd2);

    // Collision on r5: only lane1 (0xBB) is written, in a single cycle
    s_bus   = {lane(5'd5, 1'b1, 32'hBB, 32'h204), lane(5'd5, 1'b1, 32'hAA, 32'h200)};
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    check("col_we",    64'(s_we),    64'd1);
    check("col_dest",  64'(s_wdest), 64'd5);
    check("col_data",  64'(s_wdata), 64'hBB);
    check("col_over",  64'(s_over),  64'd1);
    check("col_cdest", 64'(s_cdest), 64'h0A0);
    step();
    check("col_after_we", 64'(s_we), 64'd0);
    check("col_cnt",      s_cnt,     64'd4);

    // No active lane: dest=0 with we=1, and we=0
    s_bus   = {lane(5'd9, 1'b0, 32'h99, 32'h304), lane(5'd0, 1'b1, 32'h55, 32'h300)};
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    check("idle_we",      64'(s_we),      64'd0);
    check("idle_over",    64'(s_over),    64'd1);
    check("idle_cdest",   64'(s_cdest),   64'd0);
    check("idle_allowin", 64'(s_allowin), 64'd1);
    step();
    check("idle_cnt", s_cnt, 64'd6);

    // Flush in cycle+1 of a two-lane drain
    s_bus   = {lane(5'd7, 1'b1, 32'h77, 32'h404), lane(5'd3, 1'b1, 32'h33, 32'h400)};
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    check("fl_pre_we", 64'(s_we), 64'd1);
    s_flush = 1'b1;
    #1;
    check("fl_we_forced", 64'(s_we),   64'd0);
    check("fl_no_over",   64'(s_over), 64'd0);
    step();
    s_flush = 1'b0;
    #1;
    check("fl_allowin", 64'(s_allowin), 64'd1);
    check("fl_cdest",   64'(s_cdest),   64'd0);
    check("fl_we_next", 64'(s_we),      64'd0);
    check("fl_cnt",     s_cnt,          64'd6);
    step();
    check("fl_lane1_never", 64'(s_we), 64'd0);

    // Flush beats a simultaneous capture
    s_bus   = {lane(5'd8, 1'b1, 32'h88, 32'h504), lane(5'd4, 1'b1, 32'h44, 32'h500)};
    s_valid = 1'b1;
    s_flush = 1'b1;
    step();
    s_valid = 1'b0;
    s_flush = 1'b0;
    #1;
    check("flcap_we",    64'(s_we),    64'd0);
    check("flcap_cdest", 64'(s_cdest), 64'd0);
    step();
    check("flcap_cnt", s_cnt, 64'd6);

    // Parallel ports: four back-to-back bundles, one over pulse each
    p_bus   = {lane(5'd10, 1'b1, 32'h200, 32'h0), lane(5'd1, 1'b1, 32'h100, 32'h0)};
    p_valid = 1'b1;
    #1;
    check("par_allowin0", 64'(p_allowin), 64'd1);
    step();
    for (int k = 0; k < 4; k++) begin
      logic [2*ADDR_W-1:0] exp_dest;
      logic [2*DATA_W-1:0] exp_data;
      exp_dest = {5'(k + 10), 5'(k + 1)};
      exp_data = {32'(32'h200 + k), 32'(32'h100 + k)};
      check($sformatf("par_b%0d_we", k),      64'(p_we),      64'd3);
      check($sformatf("par_b%0d_dest", k),    64'(p_wdest),   64'(exp_dest));
      check($sformatf("par_b%0d_data", k),    64'(p_wdata),   exp_data);
      check($sformatf("par_b%0d_over", k),    64'(p_over),    64'd1);
      check($sformatf("par_b%0d_allowin", k), 64'(p_allowin), 64'd1);
      if (k < 3) p_bus = {lane(5'(k + 11), 1'b1, 32'(32'h200 + k + 1), 32'h0),
                          lane(5'(k + 2),  1'b1, 32'(32'h100 + k + 1), 32'h0)};
      else       p_valid = 1'b0;
      step();
    end
    check("par_idle_over", 64'(p_over), 64'd0);
    check("par_cnt",       p_cnt,       64'd8);

    // Reset asserted in cycle 1 of a serial drain
    s_bus   = {lane(5'd7, 1'b1, 32'h22, 32'h604), lane(5'd3, 1'b1, 32'h11, 32'h600)};
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    check("mrst_pre_we", 64'(s_we), 64'd1);
    resetn = 1'b0;
    #1;
    check("mrst_we",      64'(s_we),      64'd0);
    check("mrst_over",    64'(s_over),    64'd0);
    check("mrst_cdest",   64'(s_cdest),   64'd0);
    check("mrst_allowin", 64'(s_allowin), 64'd1);
    check("mrst_cnt",     s_cnt,          64'd0);
    check("mrst_p_cnt",   p_cnt,          64'd0);
    step();
    resetn = 1'b1;
    step();
    check("mrst_rel_we",      64'(s_we),      64'd0);
    check("mrst_rel_allowin", 64'(s_allowin), 64'd1);
    check("mrst_rel_cnt",     s_cnt,          64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
